// File: rtl/subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM encoding and counter sizing.
package subtractor_pkg;

  typedef enum logic [1:0] {
    SUB_IDLE = 2'd0,
    SUB_CALC = 2'd1,
    SUB_DONE = 2'd2
  } sub_state_e;

  // Bit counter only has to reach width-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/subtractor_1bit_full.sv
// 1-bit full subtractor: diff = a - b - borrow, with borrow-out.
module subtractor_1bit_full (
  input  logic i_num_a,
  input  logic i_num_b,
  input  logic i_brw,
  output logic o_res,
  output logic o_brw
);

  assign o_res = i_num_a ^ i_num_b ^ i_brw;
  assign o_brw = (~i_num_a & i_num_b) | (~(i_num_a ^ i_num_b) & i_brw);

endmodule

// File: rtl/subtractor_nbit_serial.sv
// Bit-serial N-bit subtractor, LSB first, valid/ready on both sides.
// Optional result flags (o_zro, o_ovf) are built when
// SUBTRACTOR_NBIT_SERIAL_FLAG_EN is defined.
module subtractor_nbit_serial
  import subtractor_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vld,
  output logic                  o_rdy,
  input  logic [DATA_WIDTH-1:0] i_num_a,
  input  logic [DATA_WIDTH-1:0] i_num_b,
  input  logic                  i_brw,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_brw
`ifdef SUBTRACTOR_NBIT_SERIAL_FLAG_EN
  ,
  output logic                  o_zro,
  output logic                  o_ovf
`endif
);

  localparam int            CW       = cnt_width(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  sub_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
  logic                  brw_q;
  logic [CW-1:0]         cnt_q;
  logic                  d_bit, d_brw;
  logic                  accept, calc_last;

  assign accept    = (state == SUB_IDLE) && i_vld;
  assign calc_last = (state == SUB_CALC) && (cnt_q == CNT_LAST);

  subtractor_1bit_full u_fs (
    .i_num_a (a_q[0]),
    .i_num_b (b_q[0]),
    .i_brw   (brw_q),
    .o_res   (d_bit),
    .o_brw   (d_brw)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= SUB_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: accept -> N shift cycles -> hold result until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      SUB_IDLE: if (i_vld)     state_nxt = SUB_CALC;
      SUB_CALC: if (calc_last) state_nxt = SUB_DONE;
      SUB_DONE: if (i_rdy)     state_nxt = SUB_IDLE;
      default:                 state_nxt = SUB_IDLE;
    endcase
  end

  // Operand/result shift registers, borrow flop and bit counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      brw_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q   <= i_num_a;
      b_q   <= i_num_b;
      brw_q <= i_brw;
      cnt_q <= '0;
    end else if (state == SUB_CALC) begin
      a_q   <= {1'b0, a_q[DATA_WIDTH-1:1]};
      b_q   <= {1'b0, b_q[DATA_WIDTH-1:1]};
      res_q <= {d_bit, res_q[DATA_WIDTH-1:1]};
      brw_q <= d_brw;
      if (!calc_last) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_rdy = (state == SUB_IDLE);
  assign o_vld = (state == SUB_DONE);
  assign o_res = res_q;
  assign o_brw = brw_q;

`ifdef SUBTRACTOR_NBIT_SERIAL_FLAG_EN
  logic a_msb_q, b_msb_q, zro_q, ovf_q;

  // Operand MSBs are lost to shifting, so keep them for the overflow flag;
  // flags are captured with the final difference bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zro_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= i_num_a[DATA_WIDTH-1];
      b_msb_q <= i_num_b[DATA_WIDTH-1];
    end else if (calc_last) begin
      zro_q <= ({d_bit, res_q[DATA_WIDTH-1:1]} == '0);
      ovf_q <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
    end
  end

  assign o_zro = zro_q;
  assign o_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_nbit_serial.sv
// Self-checking bench for subtractor_nbit_serial at DATA_WIDTH=8.
module tb_subtractor_nbit_serial;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_vld = 1'b0;
  logic         o_rdy;
  logic [W-1:0] i_num_a = '0;
  logic [W-1:0] i_num_b = '0;
  logic         i_brw = 1'b0;
  logic         o_vld;
  logic         i_rdy = 1'b0;
  logic [W-1:0] o_res;
  logic         o_brw;
`ifdef SUBTRACTOR_NBIT_SERIAL_FLAG_EN
  logic         o_zro, o_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  subtractor_nbit_serial #(.DATA_WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_vld   (i_vld),
    .o_rdy   (o_rdy),
    .i_num_a (i_num_a),
    .i_num_b (i_num_b),
    .i_brw   (i_brw),
    .o_vld   (o_vld),
    .i_rdy   (i_rdy),
    .o_res   (o_res),
    .o_brw   (o_brw)
`ifdef SUBTRACTOR_NBIT_SERIAL_FLAG_EN
    ,
    .o_zro   (o_zro),
    .o_ovf   (o_ovf)
`endif
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation from IDLE; hold = cycles of backpressure in DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bi, input int hold);
    logic [W:0]   full;
    logic [W-1:0] er;
    logic         eb;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    er   = full[W-1:0];
    eb   = full[W];
    chk1("rdy_idle", o_rdy, 1'b1);
    i_vld = 1'b1; i_num_a = a; i_num_b = b; i_brw = bi;
    tick();
    // Inputs must be ignored outside IDLE.
    i_vld = 1'($urandom); i_num_a = 8'($urandom); i_num_b = 8'($urandom);
    i_brw = 1'($urandom); i_rdy = 1'($urandom);
    for (int k = 1; k <= W; k++) begin
      chk1("rdy_calc", o_rdy, 1'b0);
      chk1("vld_calc", o_vld, 1'b0);
      tick();
    end
    i_vld = 1'b0; i_rdy = 1'b0;
    chk1("vld_done", o_vld, 1'b1);
    chk1("rdy_done", o_rdy, 1'b0);
    chk8("res", o_res, er);
    chk1("brw", o_brw, eb);
`ifdef SUBTRACTOR_NBIT_SERIAL_FLAG_EN
    chk1("zro", o_zro, er == '0);
    chk1("ovf", o_ovf, (a[W-1] != b[W-1]) && (er[W-1] != a[W-1]));
`endif
    for (int h = 0; h < hold; h++) begin
      tick();
      chk1("vld_hold", o_vld, 1'b1);
      chk8("res_hold", o_res, er);
      chk1("brw_hold", o_brw, eb);
    end
    i_rdy = 1'b1;
    tick();
    i_rdy = 1'b0;
    chk1("vld_exit", o_vld, 1'b0);
    chk1("rdy_exit", o_rdy, 1'b1);
    chk8("res_kept", o_res, er);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_rdy"}, o_rdy, 1'b1);
    chk1({tag, "_vld"}, o_vld, 1'b0);
    chk8({tag, "_res"}, o_res, 8'h00);
    chk1({tag, "_brw"}, o_brw, 1'b0);
`ifdef SUBTRACTOR_NBIT_SERIAL_FLAG_EN
    chk1({tag, "_zro"}, o_zro, 1'b0);
    chk1({tag, "_ovf"}, o_ovf, 1'b0);
`endif
  endtask

  initial begin
    tick();
    tick();
    chk_reset_vals("rst0");
    i_rst = 1'b0;
    tick();
    chk_reset_vals("post_rst");

    // Directed cases.
    run_op(8'h05, 8'h03, 1'b0, 0);
    run_op(8'h03, 8'h05, 1'b0, 0);
    run_op(8'h00, 8'h00, 1'b1, 0);
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    run_op(8'hA7, 8'h3C, 1'b1, 5);

    // Reset at CALC bit 4 discards the partial result.
    i_vld = 1'b1; i_num_a = 8'hC3; i_num_b = 8'h21; i_brw = 1'b0;
    tick();
    i_vld = 1'b0;
    repeat (4) tick();
    chk1("mid_calc_rdy", o_rdy, 1'b0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_reset_vals("rst_calc");
    run_op(8'h10, 8'h01, 1'b0, 0);

    // Reset while DONE is backpressured.
    i_vld = 1'b1; i_num_a = 8'h00; i_num_b = 8'h01; i_brw = 1'b1;
    tick();
    i_vld = 1'b0;
    repeat (W + 2) tick();
    chk1("bp_vld", o_vld, 1'b1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk_reset_vals("rst_done");

`ifdef SUBTRACTOR_NBIT_SERIAL_FLAG_EN
    run_op(8'h80, 8'h01, 1'b0, 0);
    run_op(8'h42, 8'h42, 1'b0, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 1);
`endif

    // Randomized operations against the arithmetic model.
    for (int r = 0; r < 40; r++)
      run_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/subtractor_nbit_serial.md
Name: subtractor_nbit_serial

Overview:
- Bit-serial N-bit subtractor computing res = a - b - borrow_in, one bit per cycle, LSB first.
- It is the inverse-direction counterpart of the team's 1-bit full adder: it propagates a borrow where the adder propagates a carry.
- Used in area-constrained datapaths (multi-cycle ALU, divider pre-stages) where a full-width subtractor is too large.
- Operands enter and results leave over valid/ready handshakes.

Parameters:
- DATA_WIDTH, 32, operand and result width in bits; legal range is 2 or more.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_vld  input  1  input operands valid.
- o_rdy  output 1  block can accept operands.
- i_num_a  input  DATA_WIDTH  minuend.
- i_num_b  input  DATA_WIDTH  subtrahend.
- i_brw  input  1  borrow-in applied at bit 0.
- o_vld  output 1  result valid.
- i_rdy  input  1  downstream accepts the result.
- o_res  output DATA_WIDTH  difference.
- o_brw  output 1  borrow-out from the MSB (1 when a < b + borrow_in, unsigned).

Behaviour:
- Clock and reset are decided: one clock, i_clk; reset i_rst is synchronous and active-high.
- Reset values: state IDLE; o_rdy=1, o_vld=0, o_res=0, o_brw=0. Internal operand shift registers, borrow flop and bit counter are all 0.
- FSM state IDLE:
  - o_rdy=1.
  - On i_vld&&o_rdy, latch a, b and i_brw into the shift registers and borrow flop; clear the counter; go to CALC.
- FSM state CALC:
  - o_rdy=0, o_vld=0.
  - Each cycle, the 1-bit full subtractor takes a[0], b[0] and the borrow flop.
  - The difference bit shifts into the MSB of the result register, which shifts right.
  - The new borrow is registered; a and b shift right; the counter increments.
  - When counter==DATA_WIDTH-1, go to DONE.
- FSM state DONE:
  - o_vld=1; o_res and o_brw are held stable.
  - On i_rdy, go to IDLE next cycle.
- Latency: handshake in cycle T, CALC spans T+1..T+DATA_WIDTH, o_vld is first high in cycle T+DATA_WIDTH+1.
- Throughput: at most one operation per DATA_WIDTH+2 cycles. No new input is accepted in the DONE-exit cycle.
- Backpressure: while o_vld=1 and i_rdy=0, o_res, o_brw and o_vld do not change.
- i_vld, i_num_a, i_num_b and i_brw are ignored outside IDLE. Upstream must hold them only until the handshake.
- Arithmetic is modulo 2^DATA_WIDTH, with borrow-out equal to the final borrow flop.
- Counter width is $clog2(DATA_WIDTH). No wrap beyond DATA_WIDTH-1.
- Reset asserted in any state, including mid-CALC or DONE with backpressure, returns all outputs to reset values on the next edge. The partial result is discarded.
- o_res is not cleared on leaving DONE; it holds the last result until the next DONE.

Optional Feature:
- Macro: SUBTRACTOR_NBIT_SERIAL_FLAG_EN.
- Defined: adds output ports o_zro (1 bit, result==0) and o_ovf (1 bit, signed overflow).
  - o_ovf = (a_msb != b_msb) && (res_msb != a_msb), using the original latched operand MSBs.
  - Both flags are registered on the CALC-to-DONE transition, valid while o_vld=1, held under backpressure, and reset to 0.
- Undefined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Package subtractor_pkg holds:
  - the FSM enum sub_state_e {SUB_IDLE, SUB_CALC, SUB_DONE} in 2 bits;
  - the localparam function for the counter width.
- Sub-module subtractor_1bit_full:
  - inputs i_num_a, i_num_b, i_brw; outputs o_res, o_brw;
  - o_res = a^b^brw;
  - o_brw = (~a&b) | (~(a^b)&brw);
  - instantiated once inside CALC datapath.

Test Plan (DATA_WIDTH=8):
- a=0x05, b=0x03, brw=0, accept at T -> o_vld first high at T+9, o_res=0x02, o_brw=0, o_rdy low during T+1..T+9.
- a=0x03, b=0x05, brw=0 -> o_res=0xFE, o_brw=1.
- a=0x00, b=0x00, brw=1 -> o_res=0xFF, o_brw=1; then a=0xFF, b=0xFF, brw=0 -> o_res=0x00, o_brw=0.
- Hold i_rdy=0 for 5 cycles after o_vld -> o_res, o_brw and o_vld stable all 5 cycles. Release -> o_vld=0 and o_rdy=1 next cycle.
- Assert i_rst for 1 cycle at CALC bit 4 -> next cycle o_vld=0, o_rdy=1, o_res=0. A new a=0x10, b=0x01 afterwards yields 0x0F.
- With SUBTRACTOR_NBIT_SERIAL_FLAG_EN defined:
  - a=0x80, b=0x01 -> o_res=0x7F, o_ovf=1, o_zro=0;
  - a=0x42, b=0x42 -> o_zro=1, o_ovf=0.
